// File: rtl/bcd_seg_pkg.sv
// Shared types and glyph constants for the 3-digit BCD 7-segment scanner.
package bcd_seg_pkg;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  localparam int unsigned NDIG = 3;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] GLYPH_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg_scan_decode.sv
// Combinational BCD nibble to active-high 7-segment glyph; invalid codes A-F map to a dash.
module seg7_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_DASH;
    case (nibble)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit 7-segment driver with frame-synchronous value swap and inter-digit blanking.
// Optional leading-zero blanking when BCD_SEG_LZB_EN is defined.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 27_000_000,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  state_t        state_q, state_d;
  logic [11:0]   pending_q, pending_d;
  logic          pending_full_q, pending_full_d;
  logic [11:0]   shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  logic          wrap;
  logic          boundary;
  logic          accept;
  logic          digit_blank;
  logic [3:0]    cur_nib;
  logic [6:0]    glyph_hi;
  logic [6:0]    seg_hi;
  logic [2:0]    an_hi;

  seg7_decode u_dec (
    .nibble (cur_nib),
    .glyph  (glyph_hi)
  );

  always_comb begin
    cur_nib = shadow_q[11:8];
    case (digit_q)
      2'd0:    cur_nib = shadow_q[3:0];
      2'd1:    cur_nib = shadow_q[7:4];
      default: cur_nib = shadow_q[11:8];
    endcase
  end

  always_comb begin
    digit_blank = 1'b0;
`ifdef BCD_SEG_LZB_EN
    if (digit_q == 2'd2 && shadow_q[11:8] == 4'd0) digit_blank = 1'b1;
    if (digit_q == 2'd1 && shadow_q[11:4] == 8'd0) digit_blank = 1'b1;
`endif
  end

  always_comb begin
    wrap     = (cnt_q == CW'(DIV - 1));
    boundary = wrap && (digit_q == 2'(NDIG - 1));
    accept   = bcd_valid && !pending_full_q;

    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    digit_d = digit_q;
    if (wrap) digit_d = boundary ? 2'd0 : digit_q + 2'd1;
    state_d = (cnt_d >= CW'(BLANK_CYC)) ? S_SHOW : S_BLANK;

    // Ready is low whenever pending is full, so accept and boundary-swap never collide
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    shadow_d       = shadow_q;
    if (accept) begin
      pending_d      = bcd_in;
      pending_full_d = 1'b1;
    end else if (boundary && pending_full_q) begin
      shadow_d       = pending_q;
      pending_full_d = 1'b0;
    end
    frame_done_d = boundary;

    seg_hi = digit_blank ? GLYPH_OFF : glyph_hi;
    an_hi  = '0;
    if (state_q == S_SHOW && !digit_blank) begin
      case (digit_q)
        2'd0:    an_hi = 3'b001;
        2'd1:    an_hi = 3'b010;
        default: an_hi = 3'b100;
      endcase
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d  = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      digit_q        <= '0;
      state_q        <= S_BLANK;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      shadow_q       <= '0;
      seg_q          <= SEG_OFF;
      an_q           <= AN_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      digit_q        <= digit_d;
      state_q        <= state_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      shadow_q       <= shadow_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bcd_ready  = ~pending_full_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
